// File: rtl/uc_pkg.sv
// uc_pkg: shared definitions for the single-cycle control unit.
//   - Opcode constants for the non-ALU instructions (opcode[5] = 1).
//   - ALU operation width.
//   - FSM state type (RUN / SKIP / HALT).
//   - Control vector struct carried from the decoder to the top.
package uc_pkg;

  localparam int unsigned ALU_OP_W = 3;

  localparam logic [5:0] OP_LI   = 6'b100000;
  localparam logic [5:0] OP_J    = 6'b100001;
  localparam logic [5:0] OP_JZ   = 6'b100010;
  localparam logic [5:0] OP_JNZ  = 6'b100011;
  localparam logic [5:0] OP_SKZ  = 6'b100100;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SKIP = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef struct packed {
    logic                s_inc;
    logic                s_inm;
    logic                we3;
    logic [ALU_OP_W-1:0] op;
  } ctrl_t;

  // Idle control word: fall through to PC+1, write nothing.
  localparam ctrl_t CTRL_NOP = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, op: '0};

endpackage

// File: rtl/uc_decoder.sv
// uc_decoder: purely combinational instruction decode for the RUN state.
// Ports:
//   opcode_i  [5:0] instruction opcode field
//   zflag_i         registered ALU zero flag
//   ctrl_o          control vector (s_inc, s_inm, we3, op)
//   is_alu_o        instruction is in the ALU class (updates zflag)
//   is_skz_o        instruction is SKZ
//   is_halt_o       instruction is HALT
module uc_decoder
  import uc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic       zflag_i,
  output ctrl_t      ctrl_o,
  output logic       is_alu_o,
  output logic       is_skz_o,
  output logic       is_halt_o
);

  always_comb begin
    ctrl_o    = CTRL_NOP;
    is_alu_o  = 1'b0;
    is_skz_o  = 1'b0;
    is_halt_o = 1'b0;

    if (!opcode_i[5]) begin
      ctrl_o.op  = opcode_i[4:2];
      ctrl_o.we3 = 1'b1;
      is_alu_o   = 1'b1;
    end else begin
      case (opcode_i)
        OP_LI: begin
          ctrl_o.s_inm = 1'b1;
          ctrl_o.we3   = 1'b1;
        end
        OP_J:    ctrl_o.s_inc = 1'b0;
        OP_JZ:   ctrl_o.s_inc = ~zflag_i;
        OP_JNZ:  ctrl_o.s_inc = zflag_i;
        OP_SKZ:  is_skz_o = 1'b1;
        OP_HALT: begin
          // Target is the instruction's own address, so the PC parks here.
          ctrl_o.s_inc = 1'b0;
          is_halt_o    = 1'b1;
        end
        default: ;  // unlisted opcodes act as NOP
      endcase
    end
  end

endmodule

// File: rtl/uc_control.sv
// uc_control: single-cycle processor control unit.
// Control outputs are combinational in opcode, state and the registered zero
// flag; only the FSM state, zflag and the optional instruction counter are flops.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   opcode [5:0]   instruction opcode
//   z              ALU zero flag for the current instruction
//   s_inc          PC select (1 = PC+1, 0 = jump target)
//   s_inm          write-data select (1 = immediate, 0 = ALU)
//   we3            register-file write enable
//   op     [2:0]   ALU operation
//   halted         FSM is in HALT
//   icount [15:0]  retired-instruction count
// Build option: define UC_PERF_CNT_EN to include the icount counter; otherwise
// icount is tied to zero and no counter flops exist.
module uc_control
  import uc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic                z,
  output logic                s_inc,
  output logic                s_inm,
  output logic                we3,
  output logic [ALU_OP_W-1:0] op,
  output logic                halted,
  output logic [15:0]         icount
);

  state_e state_q, state_d;
  logic   zflag_q, zflag_d;
  ctrl_t  dec_ctrl, ctrl;
  logic   is_alu, is_skz, is_halt;

  uc_decoder u_decoder (
    .opcode_i  (opcode),
    .zflag_i   (zflag_q),
    .ctrl_o    (dec_ctrl),
    .is_alu_o  (is_alu),
    .is_skz_o  (is_skz),
    .is_halt_o (is_halt)
  );

  always_comb begin
    state_d = state_q;
    zflag_d = zflag_q;
    ctrl    = dec_ctrl;

    unique case (state_q)
      RUN: begin
        if (is_alu) zflag_d = z;
        if (is_halt) begin
          state_d = HALT;
        end else if (is_skz && zflag_q) begin
          state_d = SKIP;
        end
      end
      SKIP: begin
        // Squash the skipped instruction; always back to RUN so SKZ never chains.
        ctrl    = CTRL_NOP;
        state_d = RUN;
      end
      HALT: begin
        ctrl       = CTRL_NOP;
        ctrl.s_inc = 1'b0;
      end
      default: begin
        ctrl    = CTRL_NOP;
        state_d = RUN;
      end
    endcase

    // Outputs must show reset values while reset is held, whatever the opcode.
    if (reset) ctrl = CTRL_NOP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      zflag_q <= zflag_d;
    end
  end

  assign s_inc  = ctrl.s_inc;
  assign s_inm  = ctrl.s_inm;
  assign we3    = ctrl.we3;
  assign op     = ctrl.op;
  assign halted = (state_q == HALT);

`ifdef UC_PERF_CNT_EN
  logic [15:0] icount_q;

  // Counts every RUN cycle, including HALT's entry cycle; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      icount_q <= '0;
    end else if (state_q == RUN) begin
      icount_q <= icount_q + 16'd1;
    end
  end

  assign icount = icount_q;
`else
  assign icount = 16'h0000;
`endif

endmodule
